// File: rtl/ps2_keyb_rx_pkg.sv
// ps2_keyb_rx_pkg
//   Shared definitions for the PS/2 keyboard receiver: frame FSM state
//   encoding, the E0/F0 prefix byte values and the odd-parity check helper.
package ps2_keyb_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // PS/2 frames carry odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keyb_rx_line_filter.sv
// ps2_keyb_rx_line_filter
//   Brings the raw PS/2 clock into the clk domain (2-flop synchroniser), then
//   only accepts a new level after FILTER_LEN identical synchronised samples.
//   A falling edge of the filtered level gives a one-cycle fall_o pulse.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous reset, active-high (filtered level resets to 1)
//   raw_i  in  raw asynchronous line
//   fall_o out one-cycle pulse on each accepted high->low transition
module ps2_keyb_rx_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic fall_o
);

  localparam int CNT_W = $clog2(FILTER_LEN);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  // Filter: count consecutive samples that disagree with the accepted level;
  // the FILTER_LEN-th disagreeing sample flips the level.
  always_comb begin
    sync_d = {sync_q[0], raw_i};
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
        cnt_d   = '0;
      end else begin
        level_d = level_q;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else begin
      level_d = level_q;
      cnt_d   = '0;
    end
    fall_d = level_q & ~level_d;
  end

  // Synchroniser, filter and edge-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_keyb_rx.sv
// ps2_keyb_rx
//   PS/2 keyboard receiver: deframes 11-bit device-to-host frames, strips
//   E0/F0 prefixes and presents one scancode per key event.
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   clkps2, dataps2  raw PS/2 connector lines (asynchronous)
//   scancode         last decoded scancode (prefixes removed), held
//   extended         scancode was preceded by E0, held
//   released         scancode was preceded by F0, held
//   kb_int           1-cycle strobe: new scancode/extended/released valid
//   parity_err       1-cycle strobe: frame dropped on bad parity
//   frame_err        1-cycle strobe: frame dropped on bad stop bit or timeout
module ps2_keyb_rx
  import ps2_keyb_rx_pkg::*;
#(
  parameter int CLKFREQ_KHZ = 7000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       kb_int,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TMO   = CLKFREQ_KHZ * TIMEOUT_US / 1000;
  localparam int TMO_W = $clog2(TMO + 1);

  logic             fall_s, data_s, tmo_hit_s;
  ps2_state_e       state_q, state_d;
  logic [1:0]       dsync_q, dsync_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic [7:0]       scancode_q, scancode_d;
  logic             extended_q, extended_d, released_q, released_d;
  logic             kb_int_q, kb_int_d, parity_err_q, parity_err_d, frame_err_q, frame_err_d;

  ps2_keyb_rx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (clkps2),
    .fall_o (fall_s)
  );

  assign dsync_d = {dsync_q[0], dataps2};
  assign data_s  = dsync_q[1];
  // Counter value TMO-1 here means TMO cycles have elapsed since the last fall.
  assign tmo_hit_s = (state_q != ST_IDLE) && !fall_s && (tmo_q == TMO_W'(TMO - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: advances on fall, aborts to IDLE on timeout.
  always_comb begin
    state_d = state_q;
    if (tmo_hit_s) begin
      state_d = ST_IDLE;
    end else if (fall_s) begin
      case (state_q)
        ST_IDLE:   state_d = data_s ? ST_IDLE : ST_DATA;
        ST_DATA:   state_d = (bit_cnt_q == 3'd7) ? ST_PARITY : ST_DATA;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output/datapath logic: shift register, timeout counter, prefix flags, strobes.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    scancode_d   = scancode_q;
    extended_d   = extended_q;
    released_d   = released_q;
    kb_int_d     = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    if ((state_q == ST_IDLE) || fall_s) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (tmo_hit_s) begin
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end else if (fall_s) begin
      case (state_q)
        ST_IDLE: bit_cnt_d = 3'd0;
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        ST_PARITY: par_d = data_s;
        ST_STOP: begin
          if (!data_s) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end else if (!odd_parity_ok(shift_q, par_q)) begin
            parity_err_d = 1'b1;
            ext_d        = 1'b0;
            brk_d        = 1'b0;
          end else if (shift_q == PS2_PREFIX_EXT) begin
            ext_d = 1'b1;
          end else if (shift_q == PS2_PREFIX_BRK) begin
            brk_d = 1'b1;
          end else begin
            scancode_d = shift_q;
            extended_d = ext_q;
            released_d = brk_q;
            kb_int_d   = 1'b1;
            ext_d      = 1'b0;
            brk_d      = 1'b0;
          end
        end
        default: bit_cnt_d = bit_cnt_q;
      endcase
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsync_q      <= 2'b11;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      scancode_q   <= 8'h00;
      extended_q   <= 1'b0;
      released_q   <= 1'b0;
      kb_int_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      dsync_q      <= dsync_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      scancode_q   <= scancode_d;
      extended_q   <= extended_d;
      released_q   <= released_d;
      kb_int_q     <= kb_int_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign scancode   = scancode_q;
  assign extended   = extended_q;
  assign released   = released_q;
  assign kb_int     = kb_int_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keyb_rx.sv
`timescale 1ns/1ps
module tb_ps2_keyb_rx;

  localparam int FILTER_LEN = 8;
  localparam int TMO        = 1400;
  localparam int HALF_SLOW  = 350;  // 10 kHz PS/2 clock at 7 MHz
  localparam int HALF_FAST  = 40;
  localparam int LAT        = 2 + FILTER_LEN + 1;

  typedef struct {
    logic [7:0] b;
    bit         flip;
    bit         bstop;
    bit         e_kb;
    bit         e_pe;
    bit         e_fe;
    logic [7:0] e_sc;
    bit         e_ext;
    bit         e_rel;
  } vec_t;

  logic       clk, rst, clkps2, dataps2;
  logic [7:0] scancode;
  logic       extended, released, kb_int, parity_err, frame_err;

  int n_cmp = 0;
  int n_mis = 0;
  int cnt_kb = 0, cnt_pe = 0, cnt_fe = 0, excl = 0;

  vec_t tbl[$];
  bit m_ext, m_brk, m_e, m_r;
  logic [7:0] m_sc;

  ps2_keyb_rx dut (
    .clk        (clk),
    .rst        (rst),
    .clkps2     (clkps2),
    .dataps2    (dataps2),
    .scancode   (scancode),
    .extended   (extended),
    .released   (released),
    .kb_int     (kb_int),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #71.428 clk = ~clk;

  // Strobe counters and exclusivity monitor.
  always @(negedge clk) begin
    if (kb_int === 1'b1) cnt_kb <= cnt_kb + 1;
    if (parity_err === 1'b1) cnt_pe <= cnt_pe + 1;
    if (frame_err === 1'b1) cnt_fe <= cnt_fe + 1;
    if ((int'(kb_int) + int'(parity_err) + int'(frame_err)) > 1) excl <= excl + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] b, input bit fl, input bit bs,
                              input bit kb, input bit pe, input bit fe,
                              input logic [7:0] sc, input bit e, input bit r);
    vec_t v;
    v.b = b; v.flip = fl; v.bstop = bs; v.e_kb = kb; v.e_pe = pe; v.e_fe = fe;
    v.e_sc = sc; v.e_ext = e; v.e_rel = r;
    return v;
  endfunction

  // Device-side frame driver: bits first..last of an 11-bit frame. lat is the
  // number of clk cycles from the last falling edge to the first strobe seen.
  task automatic send_bits(input logic [7:0] b, input bit flip, input bit bstop,
                           input int first, input int last, input int half,
                           input int gbit, output int lat);
    logic [10:0] fr;
    fr  = {~bstop, (~(^b)) ^ flip, b, 1'b0};
    lat = -1;
    for (int i = first; i <= last; i++) begin
      for (int c = 0; c < half; c++) begin
        @(negedge clk);
        if (gbit == i && c == 1) clkps2 = 1'b0;
        if (gbit == i && c == 1 + FILTER_LEN - 1) clkps2 = 1'b1;
        if (c == half / 2) dataps2 = fr[i];
      end
      @(negedge clk);
      clkps2 = 1'b0;
      lat = -1;
      for (int c = 1; c <= half; c++) begin
        @(negedge clk);
        if (lat < 0 && (kb_int === 1'b1 || parity_err === 1'b1 || frame_err === 1'b1)) lat = c;
      end
      clkps2 = 1'b1;
    end
    dataps2 = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int half, input int gbit, input string nm);
    int kb0, pe0, fe0, lat;
    kb0 = cnt_kb; pe0 = cnt_pe; fe0 = cnt_fe;
    send_bits(v.b, v.flip, v.bstop, 0, 10, half, gbit, lat);
    repeat (5) @(negedge clk);
    chk({nm, ".kb_int"}, cnt_kb - kb0, int'(v.e_kb));
    chk({nm, ".parity_err"}, cnt_pe - pe0, int'(v.e_pe));
    chk({nm, ".frame_err"}, cnt_fe - fe0, int'(v.e_fe));
    chk({nm, ".scancode"}, int'(scancode), int'(v.e_sc));
    chk({nm, ".extended"}, int'(extended), int'(v.e_ext));
    chk({nm, ".released"}, int'(released), int'(v.e_rel));
    if (v.e_kb || v.e_pe || v.e_fe) chk({nm, ".latency"}, lat, LAT);
    else chk({nm, ".no_strobe"}, lat, -1);
  endtask

  initial begin
    int kb0, fe0, lat, tot;
    vec_t v;
    rst = 1'b1; clkps2 = 1'b1; dataps2 = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.scancode", int'(scancode), 8'h00);
    chk("reset.extended", int'(extended), 0);
    chk("reset.released", int'(released), 0);
    chk("reset.strobes", int'({kb_int, parity_err, frame_err}), 0);

    // Plain make code at the real 10 kHz PS/2 rate.
    run_vec(mk(8'h1C, 0, 0, 1, 0, 0, 8'h1C, 0, 0), HALF_SLOW, -1, "slow_1c");

    tbl.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 8'h1C, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 8'h1C, 0, 0));
    tbl.push_back(mk(8'h75, 0, 0, 1, 0, 0, 8'h75, 1, 1));
    tbl.push_back(mk(8'h75, 0, 0, 1, 0, 0, 8'h75, 0, 0));
    tbl.push_back(mk(8'h29, 1, 0, 0, 1, 0, 8'h75, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 8'h75, 0, 0));
    tbl.push_back(mk(8'h1C, 0, 0, 1, 0, 0, 8'h1C, 0, 1));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 8'h1C, 0, 1));
    tbl.push_back(mk(8'h29, 1, 0, 0, 1, 0, 8'h1C, 0, 1));
    tbl.push_back(mk(8'h1C, 0, 0, 1, 0, 0, 8'h1C, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 8'h1C, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 8'h1C, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 8'h1C, 0, 0));
    tbl.push_back(mk(8'h6B, 0, 0, 1, 0, 0, 8'h6B, 1, 1));
    tbl.push_back(mk(8'h5A, 0, 1, 0, 0, 1, 8'h6B, 1, 1));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 8'h6B, 1, 1));
    tbl.push_back(mk(8'h5A, 0, 1, 0, 0, 1, 8'h6B, 1, 1));
    tbl.push_back(mk(8'h74, 0, 0, 1, 0, 0, 8'h74, 0, 0));
    tbl.push_back(mk(8'hE0, 1, 1, 0, 0, 1, 8'h74, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 8'h74, 0, 0));
    tbl.push_back(mk(8'hF0, 1, 0, 0, 1, 0, 8'h74, 0, 0));
    tbl.push_back(mk(8'h71, 0, 0, 1, 0, 0, 8'h71, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], HALF_FAST, -1, $sformatf("tbl%0d", i));
    end

    // Glitches one sample short of the filter length: idle, then mid-frame.
    @(negedge clk);
    clkps2 = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    clkps2 = 1'b1;
    repeat (30) @(negedge clk);
    run_vec(mk(8'h12, 0, 0, 1, 0, 0, 8'h12, 0, 0), HALF_FAST, 3, "glitch_12");

    // Clock stalls after four data bits.
    kb0 = cnt_kb; fe0 = cnt_fe;
    send_bits(8'h5A, 0, 0, 0, 4, HALF_FAST, -1, lat);
    tot = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (tot < 0 && frame_err === 1'b1) tot = HALF_FAST + k;
    end
    n_cmp++;
    if (tot < TMO + 2 + FILTER_LEN - 2 || tot > TMO + 2 + FILTER_LEN + 4) begin
      n_mis++;
      $display("FAIL timeout.delay: got %0d cycles expected %0d..%0d", tot,
               TMO + 2 + FILTER_LEN - 2, TMO + 2 + FILTER_LEN + 4);
    end
    chk("timeout.frame_err_count", cnt_fe - fe0, 1);
    chk("timeout.kb_int_count", cnt_kb - kb0, 0);
    run_vec(mk(8'h5A, 0, 0, 1, 0, 0, 8'h5A, 0, 0), HALF_FAST, -1, "after_tmo_5a");

    // Reset in the middle of a frame, with an E0 prefix pending.
    run_vec(mk(8'hE0, 0, 0, 0, 0, 0, 8'h5A, 0, 0), HALF_FAST, -1, "pre_rst_e0");
    send_bits(8'h1C, 0, 0, 0, 4, HALF_FAST, -1, lat);
    @(negedge clk);
    #5 rst = 1'b1;
    #1;
    chk("midrst.scancode", int'(scancode), 8'h00);
    chk("midrst.extended", int'(extended), 0);
    chk("midrst.released", int'(released), 0);
    chk("midrst.strobes", int'({kb_int, parity_err, frame_err}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    kb0 = cnt_kb;
    send_bits(8'h1C, 0, 0, 5, 10, HALF_FAST, -1, lat);
    repeat (TMO + 200) @(negedge clk);
    chk("midrst.tail_kb_int", cnt_kb - kb0, 0);
    run_vec(mk(8'h33, 0, 0, 1, 0, 0, 8'h33, 0, 0), HALF_FAST, -1, "after_rst_33");

    // Random frames against an event-level reference model.
    m_ext = 1'b0; m_brk = 1'b0; m_sc = 8'h33; m_e = 1'b0; m_r = 1'b0;
    for (int n = 0; n < 30; n++) begin
      int sel;
      sel = $urandom_range(0, 7);
      v.b     = (sel < 2) ? 8'hE0 : (sel < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      v.bstop = ($urandom_range(0, 9) == 0);
      v.flip  = ($urandom_range(0, 7) == 0);
      v.e_kb = 1'b0; v.e_pe = 1'b0; v.e_fe = 1'b0;
      if (v.bstop) begin
        v.e_fe = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
      end else if (v.flip) begin
        v.e_pe = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
      end else if (v.b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (v.b == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        v.e_kb = 1'b1; m_sc = v.b; m_e = m_ext; m_r = m_brk;
        m_ext = 1'b0; m_brk = 1'b0;
      end
      v.e_sc = m_sc; v.e_ext = m_e; v.e_rel = m_r;
      run_vec(v, HALF_FAST, -1, $sformatf("rand%0d", n));
    end

    chk("strobe_exclusive", excl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
